// File: rtl/pop_pkg.sv
// rtl/pop_pkg.sv - shared state encoding and default widths for the POP sample accumulator
package pop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } pop_acc_state_t;

  localparam int DATA_WIDTH  = 12;
  localparam int SUM_WIDTH   = 24;
  localparam int COUNT_WIDTH = 12;
  localparam int TIMEOUT     = 8;

endpackage

// File: rtl/pop_edge_detect.sv
// rtl/pop_edge_detect.sv - rising-edge pulse on sig_in, suppressed until sig_in has been seen low after reset
module pop_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_pulse
);

  logic sig_d_q, sig_d_d;
  logic armed_q, armed_d;

  // A level already high when reset releases is not an edge; arm only once it has been low.
  always_comb begin
    sig_d_d = sig_in;
    armed_d = armed_q | ~sig_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_d_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sig_d_q <= sig_d_d;
      armed_q <= armed_d;
    end
  end

  assign rise_pulse = sig_in & ~sig_d_q & armed_q;

endmodule

// File: rtl/pop_sample_accumulator.sv
// rtl/pop_sample_accumulator.sv - sums ADC conversions over a sample window with timeout and saturation
module pop_sample_accumulator #(
  parameter int DATA_WIDTH  = pop_pkg::DATA_WIDTH,
  parameter int SUM_WIDTH   = pop_pkg::SUM_WIDTH,
  parameter int COUNT_WIDTH = pop_pkg::COUNT_WIDTH,
  parameter int TIMEOUT     = pop_pkg::TIMEOUT
) (
  input  logic                   clock_2_5M,
  input  logic                   reset,
  input  logic                   sample,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  input  logic                   adc_done,
  output logic                   adc_start,
  output logic                   busy,
  output logic [SUM_WIDTH-1:0]   result_sum,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   result_err,
  output logic                   result_valid
);

  import pop_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  pop_acc_state_t state_q, state_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [SUM_WIDTH-1:0]   res_sum_q, res_sum_d;
  logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
  logic                   res_err_q, res_err_d;

  logic                   rise;
  logic [SUM_WIDTH:0]     sum_ext;
  logic [SUM_WIDTH-1:0]   sum_sat;
  logic [COUNT_WIDTH-1:0] count_inc;

  pop_edge_detect u_edge (
    .clk        (clock_2_5M),
    .reset      (reset),
    .sig_in     (sample),
    .rise_pulse (rise)
  );

  assign sum_ext   = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - DATA_WIDTH){1'b0}}, adc_data};
  assign sum_sat   = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
  assign count_inc = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    count_d     = count_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    res_sum_d   = res_sum_q;
    res_count_d = res_count_q;
    res_err_d   = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_START;
          sum_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (adc_done) begin
          sum_d   = sum_sat;
          count_d = count_inc;
          tmo_d   = '0;
          state_d = sample ? ST_START : ST_FINISH;
        end else begin
          // Timeout budget is per conversion; the stalled conversion is simply dropped.
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Load results on entry so they are already valid during the result_valid cycle.
    if (state_d == ST_FINISH) begin
      res_sum_d   = sum_d;
      res_count_d = count_d;
      res_err_d   = err_d;
    end
  end

  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      res_sum_q   <= '0;
      res_count_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      res_sum_q   <= res_sum_d;
      res_count_q <= res_count_d;
      res_err_q   <= res_err_d;
    end
  end

  assign adc_start    = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_FINISH);
  assign result_sum   = res_sum_q;
  assign result_count = res_count_q;
  assign result_err   = res_err_q;

endmodule

// File: tb/tb_pop_sample_accumulator.sv
// tb/tb_pop_sample_accumulator.sv - randomized and directed checks of pop_sample_accumulator against a window-level model
module tb_pop_sample_accumulator;

  localparam int DW = 12;
  localparam int SW = 14;
  localparam int CW = 12;
  localparam int TO = 8;
  localparam longint SMAX = (longint'(1) << SW) - 1;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic          clock_2_5M = 1'b0;
  logic          reset;
  logic          sample;
  logic [DW-1:0] adc_data;
  logic          adc_done;
  logic          adc_start;
  logic          busy;
  logic [SW-1:0] result_sum;
  logic [CW-1:0] result_count;
  logic          result_err;
  logic          result_valid;

  pop_sample_accumulator #(
    .DATA_WIDTH  (DW),
    .SUM_WIDTH   (SW),
    .COUNT_WIDTH (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clock_2_5M   (clock_2_5M),
    .reset        (reset),
    .sample       (sample),
    .adc_data     (adc_data),
    .adc_done     (adc_done),
    .adc_start    (adc_start),
    .busy         (busy),
    .result_sum   (result_sum),
    .result_count (result_count),
    .result_err   (result_err),
    .result_valid (result_valid)
  );

  always #5 clock_2_5M = ~clock_2_5M;

  int n_chk  = 0;
  int n_fail = 0;

  // ADC environment
  int            lat_cfg;
  int            pend;
  logic [DW-1:0] data_cfg;
  bit            data_rand;
  bit            stray;

  // observation counters
  int     starts_seen, rv_seen, busy_seen;
  longint cap_sum, cap_cnt, cap_err;

  // window-level reference: phase 0 idle, 1 requesting, 2 awaiting, 3 reporting
  int     m_phase;
  longint m_sum, m_cnt, r_sum, r_cnt;
  bit     m_err, r_err;
  int     m_tmo;
  bit     m_prev, m_low;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (reset) begin
      m_phase = 0; m_sum = 0; m_cnt = 0; m_err = 0; m_tmo = 0;
      m_prev = 0; m_low = 0; r_sum = 0; r_cnt = 0; r_err = 0;
    end else begin
      rise = sample && !m_prev && m_low;
      case (m_phase)
        0: if (rise) begin
          m_phase = 1; m_sum = 0; m_cnt = 0; m_err = 0; m_tmo = 0;
        end
        1: m_phase = 2;
        2: if (adc_done) begin
          m_sum = (m_sum + adc_data > SMAX) ? SMAX : m_sum + adc_data;
          m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          m_tmo = 0;
          m_phase = sample ? 1 : 3;
        end else begin
          m_tmo++;
          if (m_tmo >= TO) begin
            m_err = 1;
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
      if (m_phase == 3) begin
        r_sum = m_sum; r_cnt = m_cnt; r_err = m_err;
      end
      m_prev = sample;
      if (!sample) m_low = 1;
    end
  endtask

  task automatic compare();
    chk("adc_start", adc_start, m_phase == 1);
    chk("busy", busy, m_phase != 0);
    chk("result_valid", result_valid, m_phase == 3);
    chk("result_sum", result_sum, r_sum);
    chk("result_count", result_count, r_cnt);
    chk("result_err", result_err, r_err);
    if (adc_start) starts_seen++;
    if (busy) busy_seen++;
    if (result_valid) begin
      rv_seen++;
      cap_sum = result_sum; cap_cnt = result_count; cap_err = result_err;
    end
  endtask

  task automatic adc_env();
    bit fire;
    fire = 0;
    if (reset) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) fire = 1;
    end
    if (adc_start) pend = lat_cfg;
    if (fire) begin
      adc_done = 1'b1;
      adc_data = data_rand ? DW'($urandom) : data_cfg;
    end else if (stray) begin
      adc_done = 1'b1;
      adc_data = DW'($urandom);
    end else begin
      adc_done = 1'b0;
      adc_data = DW'($urandom);
    end
    stray = 0;
  endtask

  task automatic tick();
    @(posedge clock_2_5M);
    model_step();
    @(negedge clock_2_5M);
    compare();
    adc_env();
  endtask

  task automatic wait_result(input int bound);
    int k;
    int r0;
    k = 0;
    r0 = rv_seen;
    while (rv_seen == r0 && k < bound) begin
      tick();
      k++;
    end
    if (rv_seen == r0) chk("wait_result_bound", 0, 1);
  endtask

  task automatic clear_counts();
    starts_seen = 0; rv_seen = 0; busy_seen = 0;
  endtask

  initial begin
    reset = 1; sample = 1; adc_done = 0; adc_data = '0;
    lat_cfg = 1; pend = 0; data_cfg = 100; data_rand = 0; stray = 0;
    cap_sum = 0; cap_cnt = 0; cap_err = 0;
    clear_counts();

    // reset held with sample high
    repeat (10) tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_sum", result_sum, 0);
    chk("rst_valid", result_valid, 0);
    reset = 0;
    clear_counts();
    repeat (6) tick();
    chk("no_window_from_held_sample", busy_seen, 0);
    sample = 0; tick();
    sample = 1; tick();
    chk("fresh_edge_starts", busy, 1);
    sample = 0;
    wait_result(40);
    repeat (3) tick();

    // nominal: 20 cycles of sample, 1-cycle ADC latency, data 100
    clear_counts();
    lat_cfg = 1; data_cfg = 100;
    sample = 1;
    repeat (20) tick();
    sample = 0;
    wait_result(40);
    repeat (3) tick();
    chk("nom_rv_once", rv_seen, 1);
    chk("nom_count_eq_starts", cap_cnt, starts_seen);
    chk("nom_sum", cap_sum, 100 * starts_seen);
    chk("nom_count_literal", cap_cnt, 10);
    chk("nom_err", cap_err, 0);

    // saturation: five conversions of 4095 into a 14-bit sum
    clear_counts();
    data_cfg = 4095;
    sample = 1;
    begin
      int k;
      k = 0;
      while (starts_seen < 5 && k < 40) begin tick(); k++; end
      if (starts_seen < 5) chk("sat_start_bound", starts_seen, 5);
    end
    sample = 0;
    wait_result(40);
    repeat (3) tick();
    chk("sat_sum", cap_sum, 16383);
    chk("sat_count", cap_cnt, 5);

    // timeout: ADC never answers
    clear_counts();
    lat_cfg = 0;
    sample = 1; tick();
    sample = 0;
    wait_result(40);
    repeat (4) tick();
    chk("tmo_starts", starts_seen, 1);
    chk("tmo_busy_cycles", busy_seen, 1 + TO + 1);
    chk("tmo_err", cap_err, 1);
    chk("tmo_count", cap_cnt, 0);
    chk("tmo_sum", cap_sum, 0);

    // reset mid-window after three conversions
    clear_counts();
    lat_cfg = 1; data_cfg = 50;
    sample = 1;
    begin
      int k;
      k = 0;
      while (starts_seen < 4 && k < 40) begin tick(); k++; end
      if (starts_seen < 4) chk("mid_start_bound", starts_seen, 4);
    end
    reset = 1;
    repeat (2) tick();
    reset = 0;
    tick();
    chk("mid_no_valid", rv_seen, 0);
    chk("mid_sum_cleared", result_sum, 0);
    sample = 0; tick();
    data_cfg = 7;
    sample = 1; tick();
    sample = 0;
    wait_result(40);
    repeat (2) tick();
    chk("post_reset_sum", cap_sum, 7);
    chk("post_reset_count", cap_cnt, 1);

    // stray adc_done while idle, second sample pulse while busy
    clear_counts();
    stray = 1; tick(); tick();
    lat_cfg = 3; data_cfg = 9;
    sample = 1; tick();
    sample = 0; tick(); tick();
    sample = 1; tick();
    sample = 0;
    wait_result(40);
    repeat (4) tick();
    chk("stray_rv_once", rv_seen, 1);
    chk("stray_starts", starts_seen, 1);
    chk("stray_count", cap_cnt, 1);
    chk("stray_sum", cap_sum, 9);

    // randomized traffic against the model
    data_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) sample = ~sample;
      if ($urandom_range(0, 15) == 0) lat_cfg = $urandom_range(0, 10);
      if ($urandom_range(0, 19) == 0) stray = 1;
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 0; sample = 0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pop_sample_accumulator.md
POP_SAMPLE_ACCUMULATOR -- requirements
Module: pop_sample_accumulator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 12, ADC sample width.
- SUM_WIDTH, 24, accumulator width.
- COUNT_WIDTH, 12, conversion counter width.
- TIMEOUT, 8, max cycles in WAIT before abort.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock_2_5M  in  1  the single 2.5 MHz system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample  in  1  sample window from POPtimers.
- adc_data  in  DATA_WIDTH  conversion result; valid only when adc_done=1.
- adc_done  in  1  one-cycle conversion-complete strobe.
- adc_start  out  1  one-cycle conversion request.
- busy  out  1  high whenever state != IDLE.
- result_sum  out  SUM_WIDTH  summed samples of the last window.
- result_count  out  COUNT_WIDTH  conversions summed in the last window.
- result_err  out  1  last window aborted by timeout.
- result_valid  out  1  one-cycle strobe; result_* are stable from this strobe until the next one.

Function
REQ-003 Rising edge of sample is detected as sample=1 with registered sample_d=0; a window starts only from IDLE.
- Rising edges seen outside IDLE are ignored; no queuing.
REQ-004 FSM states: IDLE, START, WAIT, FINISH.
- IDLE->START on a detected rising edge; sum, count, err and the timeout counter clear on this transition.
REQ-005 START: adc_start=1 for exactly that one cycle; unconditional ->WAIT.
- First adc_start is high in the cycle after the clock edge that detects the rising edge.
REQ-006 WAIT with adc_done=1:
- sum <= sum + zero-extended adc_data, saturating at all-ones.
- count <= count+1, saturating at all-ones.
- Next state is START if sample=1 in that cycle, else FINISH.
REQ-007 WAIT timeout: the counter increments each WAIT cycle without adc_done.
- When it reaches TIMEOUT: err <= 1, ->FINISH regardless of sample; the pending conversion is abandoned.
REQ-008 sample falling during START or WAIT does not cancel the outstanding conversion; its result is summed.
REQ-009 FINISH lasts one cycle:
- result_sum, result_count and result_err are loaded from the working registers.
- result_valid=1 for that cycle only; ->IDLE.
REQ-010 adc_done in IDLE, START or FINISH is ignored; adc_data is not summed.
REQ-011 A window whose sample pulse falls before the first conversion completes still produces exactly one conversion and one result.
REQ-012 The outputs adc_start, busy and result_valid are decoded from registered state; there is no combinational path from input to output.

Reset
REQ-013 While reset=1 at a clock edge:
- State goes to IDLE.
- sample_d, sum, count, err and the timeout counter clear.
- All outputs are 0 (result_sum, result_count, result_err included).
REQ-014 Reset mid-window aborts it with no result_valid.
- The next window starts only on a fresh rising edge after reset deasserts; a sample already high at deassertion does not start a window.

Structure
REQ-015 Package pop_pkg holds:
- the FSM state enum (pop_acc_state_t);
- default width constants DATA_WIDTH, SUM_WIDTH and COUNT_WIDTH;
- the TIMEOUT constant.
REQ-016 Rising-edge detection is the single sub-module pop_edge_detect (registered input, one-cycle pulse output, synchronous reset); everything else is flat.

Verification
REQ-017 Reset: reset=1 for 10 cycles while sample=1 -> all outputs 0, busy=0; no window starts after reset deasserts until sample goes low then high.
REQ-018 Nominal window: ADC model returns adc_done 1 cycle after adc_start with data=100; sample high for 20 cycles -> result_count equals the number of adc_start pulses, result_sum=100*count, result_err=0, exactly one result_valid.
REQ-019 Saturation: SUM_WIDTH=14, data=4095, sample held for 5 conversions -> result_sum=16383, result_count=5.
REQ-020 Timeout: ADC never responds -> exactly one adc_start, busy for 1+TIMEOUT+1 cycles, result_err=1, result_count=0, result_sum=0.
REQ-021 Reset mid-window after 3 conversions -> no result_valid, result_sum=0; the next window's results exclude the pre-reset data.
REQ-022 Busy edges and stray strobes: a second sample pulse while busy, plus adc_done while IDLE -> ignored; result_count matches the first window only.
